// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_unit_if #(
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [BUS_W/8-1:0]   mem_sel_o;
  logic [BUS_W-1:0]     mem_data_o;
  logic [BUS_W-1:0]     mem_data_i;
  logic                 mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: sub-word big-endian loads/stores over a req/ack bus,
// alignment exceptions and LL/SC through an internal link bit.
module mem_access_unit #(
  parameter int unsigned BUS_W      = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           reg2_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  mem_access_unit_if.master     bus,
  output logic                  stallreq_o,
  output logic                  excp_adel_o,
  output logic                  excp_ades_o
);

  localparam int unsigned SEL_W = BUS_W / 8;
  localparam int unsigned OFF_W = $clog2(SEL_W);
  localparam int unsigned SH_W  = OFF_W + 3;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             llbit_q, llbit_d;
  logic             drain_q, drain_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;

  logic             is_ld, is_st, is_ll, is_sc, sgn, misalign, sc_fail, go;
  logic [1:0]       sz;
  logic [OFF_W-1:0] k;
  logic [SH_W-1:0]  shamt;
  logic [BUS_W-1:0] shifted;
  logic [31:0]      word_v, ld_data;
  logic [SEL_W-1:0] sel_v;
  logic [BUS_W-1:0] st_data;
  logic             req;

  // Opcode decode and alignment
  always_comb begin
    is_ld = 1'b0; is_st = 1'b0; is_ll = 1'b0; is_sc = 1'b0;
    sgn   = 1'b0; sz    = 2'd0;
    case (mem_op_i)
      OP_LB:   begin is_ld = 1'b1; sgn = 1'b1; end
      OP_LBU:  is_ld = 1'b1;
      OP_LH:   begin is_ld = 1'b1; sgn = 1'b1; sz = 2'd1; end
      OP_LHU:  begin is_ld = 1'b1; sz = 2'd1; end
      OP_LW:   begin is_ld = 1'b1; sz = 2'd2; end
      OP_SB:   is_st = 1'b1;
      OP_SH:   begin is_st = 1'b1; sz = 2'd1; end
      OP_SW:   begin is_st = 1'b1; sz = 2'd2; end
      OP_LL:   begin is_ld = 1'b1; is_ll = 1'b1; sz = 2'd2; end
      OP_SC:   begin is_st = 1'b1; is_sc = 1'b1; sz = 2'd2; end
      default: ;
    endcase
    misalign = ((sz == 2'd1) && mem_addr_i[0]) ||
               ((sz == 2'd2) && (mem_addr_i[1:0] != 2'b00));
    sc_fail  = is_sc && !llbit_q;
    go       = (is_ld || is_st) && !misalign && !sc_fail;
  end

  // Lane selection, store replication and load extraction (lane 0 = MSB)
  always_comb begin
    k       = mem_addr_i[OFF_W-1:0];
    shamt   = {k, 3'b000};
    shifted = rdata_q << shamt;
    word_v  = 32'(shifted >> (BUS_W - 32));
    case (sz)
      2'd0:    begin
                 sel_v   = (SEL_W'(1) << (SEL_W - 1)) >> k;
                 st_data = {SEL_W{reg2_i[7:0]}};
                 ld_data = sgn ? {{24{word_v[31]}}, word_v[31:24]} : {24'd0, word_v[31:24]};
               end
      2'd1:    begin
                 sel_v   = (SEL_W'(3) << (SEL_W - 2)) >> k;
                 st_data = {(BUS_W / 16){reg2_i[15:0]}};
                 ld_data = sgn ? {{16{word_v[31]}}, word_v[31:16]} : {16'd0, word_v[31:16]};
               end
      default: begin
                 sel_v   = (SEL_W'(15) << (SEL_W - 4)) >> k;
                 st_data = {(BUS_W / 32){reg2_i}};
                 ld_data = word_v;
               end
    endcase
  end

  // Next state; a flush seen while a request is outstanding drains it back to IDLE
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (go) begin
              if (bus.mem_ack_i) begin
                state_d = flush_i ? IDLE : DONE;
                rdata_d = bus.mem_data_i;
              end else begin
                state_d = WAIT;
                drain_d = flush_i;
              end
            end
      WAIT: if (bus.mem_ack_i) begin
              state_d = (flush_i || drain_q) ? IDLE : DONE;
              drain_d = 1'b0;
              rdata_d = bus.mem_data_i;
            end else if (flush_i) begin
              drain_d = 1'b1;
            end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i)                        llbit_d = 1'b0;
    else if (state_q == DONE && is_ll)  llbit_d = 1'b1;
    else if (state_q == DONE && is_sc)  llbit_d = 1'b0;
    else                                llbit_d = llbit_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      llbit_q <= 1'b0;
      drain_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      llbit_q <= llbit_d;
      drain_q <= drain_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs; everything is held at zero while in reset
  always_comb begin
    wd_o            = '0;
    wreg_o          = 1'b0;
    wdata_o         = '0;
    req             = 1'b0;
    stallreq_o      = 1'b0;
    excp_adel_o     = 1'b0;
    excp_ades_o     = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_sel_o   = '0;
    bus.mem_data_o  = '0;
    if (rst) begin
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      excp_adel_o = is_ld && misalign;
      excp_ades_o = is_st && misalign;
      case (state_q)
        IDLE: if ((is_ld || is_st) && misalign) begin
                wreg_o = 1'b0;
              end else if (go) begin
                req = 1'b1;
              end else if (sc_fail) begin
                wreg_o  = 1'b1;
                wdata_o = 32'd0;
              end
        WAIT: req = 1'b1;
        DONE: if (is_ld) begin
                wdata_o = ld_data;
              end else if (is_sc) begin
                wreg_o  = 1'b1;
                wdata_o = 32'd1;
              end
        default: ;
      endcase
      stallreq_o    = req;
      bus.mem_req_o = req;
      if (req) begin
        bus.mem_we_o   = is_st;
        bus.mem_addr_o = {mem_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        bus.mem_sel_o  = sel_v;
        bus.mem_data_o = st_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit on a 32-bit and a 64-bit bus.
module tb_mem_access_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8, OP_LL = 4'd9, OP_SC = 4'd10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst64, wreg, flush;
  logic [4:0]  wd;
  logic [31:0] wdata_in, addr, reg2;
  logic [3:0]  op;

  logic [4:0]  wd32_o, wd64_o;
  logic        wreg32_o, wreg64_o, stall32, stall64;
  logic        adel32, ades32, adel64, ades64;
  logic [31:0] wdata32_o, wdata64_o;

  mem_access_unit_if #(.BUS_W(32), .ADDR_W(32)) bus32 ();
  mem_access_unit_if #(.BUS_W(64), .ADDR_W(32)) bus64 ();

  mem_access_unit #(.BUS_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata_in), .mem_op_i(op),
    .mem_addr_i(addr), .reg2_i(reg2), .flush_i(flush), .wd_o(wd32_o), .wreg_o(wreg32_o),
    .wdata_o(wdata32_o), .bus(bus32), .stallreq_o(stall32), .excp_adel_o(adel32),
    .excp_ades_o(ades32));

  mem_access_unit #(.BUS_W(64), .ADDR_W(32), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst64), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata_in), .mem_op_i(op),
    .mem_addr_i(addr), .reg2_i(reg2), .flush_i(flush), .wd_o(wd64_o), .wreg_o(wreg64_o),
    .wdata_o(wdata64_o), .bus(bus64), .stallreq_o(stall64), .excp_adel_o(adel64),
    .excp_ades_o(ades64));

  typedef struct {logic [31:0] wdata; logic wreg;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access on the 32-bit unit; ack arrives after ack_after request cycles
  task automatic acc32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] rd, input int ack_after, input logic wr_in,
                       input int exp_stall, input logic [3:0] exp_sel, input logic [31:0] exp_md,
                       input logic [31:0] exp_wd, input logic exp_wr);
    int   stall_n = 0;
    logic done = 1'b0;
    logic st;
    exp_t e;
    st = (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
    @(negedge clk);
    op = o; addr = a; reg2 = r2; wreg = wr_in; wdata_in = 32'hDEAD0000;
    bus32.mem_data_i = rd; bus32.mem_ack_i = (ack_after == 0);
    sb.push_back('{exp_wd, exp_wr});
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (stall32) begin
        chk("req_stall", 64'(bus32.mem_req_o), 64'd1);
        chk("we", 64'(bus32.mem_we_o), 64'(st));
        chk("maddr", 64'(bus32.mem_addr_o), 64'({a[31:2], 2'b00}));
        chk("sel", 64'(bus32.mem_sel_o), 64'(exp_sel));
        if (st) chk("mdata", 64'(bus32.mem_data_o), 64'(exp_md));
        stall_n++;
        @(negedge clk);
        bus32.mem_ack_i = (stall_n >= ack_after);
      end else begin
        chk("req_done", 64'(bus32.mem_req_o), 64'd0);
        e = sb.pop_front();
        chk("wdata", 64'(wdata32_o), 64'(e.wdata));
        chk("wreg", 64'(wreg32_o), 64'(e.wreg));
        chk("wd", 64'(wd32_o), 64'd7);
        chk("stall_cycles", 64'(stall_n), 64'(exp_stall));
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: observed no completion, required one within 64 cycles");
    end
    @(negedge clk);
    op = OP_NONE; bus32.mem_ack_i = 1'b0;
  endtask

  // Zero-wait load on the 64-bit unit
  task automatic acc64(input logic [3:0] o, input logic [31:0] a, input logic [63:0] rd,
                       input logic [7:0] exp_sel, input logic [31:0] exp_wd);
    exp_t e;
    @(negedge clk);
    op = o; addr = a; wreg = 1'b1; bus64.mem_data_i = rd; bus64.mem_ack_i = 1'b1;
    sb.push_back('{exp_wd, 1'b1});
    #1;
    chk("s64_stall", 64'(stall64), 64'd1);
    chk("s64_sel", 64'(bus64.mem_sel_o), 64'(exp_sel));
    chk("s64_maddr", 64'(bus64.mem_addr_o), 64'({a[31:3], 3'b000}));
    @(negedge clk); #1;
    chk("s64_stall_done", 64'(stall64), 64'd0);
    e = sb.pop_front();
    chk("s64_wdata", 64'(wdata64_o), 64'(e.wdata));
    @(negedge clk);
    op = OP_NONE; bus64.mem_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish before 200us");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst64 = 1'b0; flush = 1'b0;
    wd = 5'd7; wreg = 1'b1; wdata_in = 32'hFFFFFFFF;
    op = OP_LW; addr = 32'h100; reg2 = 32'hA5A5A5A5;
    bus32.mem_data_i = '0; bus32.mem_ack_i = 1'b0;
    bus64.mem_data_i = '0; bus64.mem_ack_i = 1'b0;

    // Reset holds all outputs at zero
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("rst_wd", 64'(wd32_o), 64'd0);
      chk("rst_wreg", 64'(wreg32_o), 64'd0);
      chk("rst_wdata", 64'(wdata32_o), 64'd0);
      chk("rst_req", 64'(bus32.mem_req_o), 64'd0);
      chk("rst_addr", 64'(bus32.mem_addr_o), 64'd0);
      chk("rst_sel", 64'(bus32.mem_sel_o), 64'd0);
      chk("rst_data", 64'(bus32.mem_data_o), 64'd0);
      chk("rst_stall", 64'(stall32), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1; op = OP_NONE;

    acc32(OP_SC, 32'h40, 32'h99, 32'h0, 0, 1'b0, 0, 4'hF, 32'h0, 32'h0, 1'b1);

    // Non-memory pass-through
    @(negedge clk);
    wd = 5'd7; wreg = 1'b1; wdata_in = 32'h00C0FFEE; #1;
    chk("pass_wdata", 64'(wdata32_o), 64'h00C0FFEE);
    chk("pass_wreg", 64'(wreg32_o), 64'd1);
    chk("pass_req", 64'(bus32.mem_req_o), 64'd0);
    chk("pass_stall", 64'(stall32), 64'd0);

    acc32(OP_LB,  32'h1,   32'h0, 32'h80FF7F01, 0, 1'b1, 1, 4'b0100, 32'h0, 32'hFFFFFFFF, 1'b1);
    acc32(OP_LBU, 32'h1,   32'h0, 32'h80FF7F01, 0, 1'b1, 1, 4'b0100, 32'h0, 32'h000000FF, 1'b1);
    acc32(OP_LB,  32'h0,   32'h0, 32'h80FF7F01, 0, 1'b1, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1);
    acc32(OP_LH,  32'h0,   32'h0, 32'h80FF7F01, 0, 1'b1, 1, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b1);
    acc32(OP_LHU, 32'h2,   32'h0, 32'h80FF7F01, 0, 1'b1, 1, 4'b0011, 32'h0, 32'h00007F01, 1'b1);
    acc32(OP_LW,  32'h10,  32'h0, 32'h80FF7F01, 2, 1'b1, 3, 4'b1111, 32'h0, 32'h80FF7F01, 1'b1);
    acc32(OP_SH,  32'h102, 32'h1234ABCD, 32'h0, 3, 1'b0, 4, 4'b0011, 32'hABCDABCD, 32'hDEAD0000, 1'b0);
    acc32(OP_SB,  32'h203, 32'h000000EF, 32'h0, 1, 1'b0, 2, 4'b0001, 32'hEFEFEFEF, 32'hDEAD0000, 1'b0);
    acc32(OP_SW,  32'h300, 32'h01020304, 32'h0, 0, 1'b0, 1, 4'b1111, 32'h01020304, 32'hDEAD0000, 1'b0);

    // Misaligned accesses
    @(negedge clk);
    op = OP_LW; addr = 32'h2; wreg = 1'b1; #1;
    chk("adel", 64'(adel32), 64'd1);
    chk("adel_ades", 64'(ades32), 64'd0);
    chk("adel_req", 64'(bus32.mem_req_o), 64'd0);
    chk("adel_wreg", 64'(wreg32_o), 64'd0);
    chk("adel_stall", 64'(stall32), 64'd0);
    @(negedge clk);
    op = OP_SH; addr = 32'h3; #1;
    chk("ades", 64'(ades32), 64'd1);
    chk("ades_adel", 64'(adel32), 64'd0);
    chk("ades_req", 64'(bus32.mem_req_o), 64'd0);
    @(negedge clk);
    op = OP_NONE;

    // LL/SC pairing
    acc32(OP_LL, 32'h40, 32'h0, 32'hCAFEBABE, 0, 1'b1, 1, 4'b1111, 32'h0, 32'hCAFEBABE, 1'b1);
    acc32(OP_SC, 32'h40, 32'h5555AAAA, 32'h0, 2, 1'b0, 3, 4'b1111, 32'h5555AAAA, 32'h1, 1'b1);
    acc32(OP_SC, 32'h40, 32'h5555AAAA, 32'h0, 0, 1'b0, 0, 4'b1111, 32'h0, 32'h0, 1'b1);
    acc32(OP_LL, 32'h40, 32'h0, 32'h12345678, 0, 1'b1, 1, 4'b1111, 32'h0, 32'h12345678, 1'b1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    acc32(OP_SC, 32'h40, 32'h77, 32'h0, 0, 1'b0, 0, 4'b1111, 32'h0, 32'h0, 1'b1);

    // Flush during WAIT drains the LL without completing it
    acc32(OP_LL, 32'h80, 32'h0, 32'h1, 0, 1'b1, 1, 4'b1111, 32'h0, 32'h1, 1'b1);
    @(negedge clk);
    op = OP_LL; addr = 32'h80; bus32.mem_ack_i = 1'b0; #1;
    chk("drain_stall0", 64'(stall32), 64'd1);
    @(negedge clk); flush = 1'b1; #1;
    chk("drain_req1", 64'(bus32.mem_req_o), 64'd1);
    @(negedge clk); flush = 1'b0; #1;
    chk("drain_req2", 64'(bus32.mem_req_o), 64'd1);
    chk("drain_stall2", 64'(stall32), 64'd1);
    bus32.mem_ack_i = 1'b1;
    @(negedge clk);
    op = OP_NONE; bus32.mem_ack_i = 1'b0; #1;
    chk("drain_after", 64'(stall32), 64'd0);
    acc32(OP_SC, 32'h80, 32'h55, 32'h0, 0, 1'b0, 0, 4'b1111, 32'h0, 32'h0, 1'b1);

    // 64-bit bus
    @(negedge clk);
    rst64 = 1'b1; op = OP_NONE;
    acc64(OP_LW,  32'h4, 64'h11112222_33334444, 8'h0F, 32'h33334444);
    acc64(OP_LW,  32'h0, 64'h11112222_33334444, 8'hF0, 32'h11112222);
    acc64(OP_LB,  32'h7, 64'h11112222_33334444, 8'h01, 32'h00000044);
    acc64(OP_LHU, 32'h2, 64'h11112222_33334444, 8'h30, 32'h00002222);

    // Reset in the middle of WAIT
    @(negedge clk);
    op = OP_LW; addr = 32'h8; bus64.mem_ack_i = 1'b0; #1;
    chk("r64_stall", 64'(stall64), 64'd1);
    @(negedge clk); #1;
    chk("r64_wait_req", 64'(bus64.mem_req_o), 64'd1);
    rst64 = 1'b0; #1;
    chk("r64_rst_stall", 64'(stall64), 64'd0);
    chk("r64_rst_req", 64'(bus64.mem_req_o), 64'd0);
    @(negedge clk);
    rst64 = 1'b1; op = OP_SC; wreg = 1'b0; #1;
    chk("r64_idle_stall", 64'(stall64), 64'd0);
    chk("r64_idle_wreg", 64'(wreg64_o), 64'd1);
    chk("r64_idle_wdata", 64'(wdata64_o), 64'd0);
    @(negedge clk);
    op = OP_NONE;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
